// File: rtl/fnd_pkg.sv
// Shared constants, FSM state type and segment decoding for the FND display driver.
package fnd_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned BIN_W      = 14;
  localparam int unsigned BCD_W      = 4 * NUM_DIGITS;
  localparam logic [13:0] MAX_VALUE  = 14'd9999;
  localparam logic [7:0]  BLANK_SEG  = 8'hFF;

  // Active-low {dp,g,f,e,d,c,b,a} for digits 0..9; dp held off.
  localparam logic [7:0] SEG_PATTERNS [10] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_LOAD = 2'd2
  } conv_state_e;

  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    if (nib < 4'd10) return SEG_PATTERNS[nib];
    return BLANK_SEG;
  endfunction

endpackage

// File: rtl/fnd_display_driver_bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter with start/busy/done handshake.
module bin2bcd_seq
  import fnd_pkg::*;
(
  input  logic              sysclk,
  input  logic              i_rst_n,
  input  logic              start_i,
  input  logic [BIN_W-1:0]  bin_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [BCD_W-1:0]  bcd_o,
  output logic              ovf_o
);

  localparam logic [3:0] LAST_ITER = 4'(BIN_W - 1);

  conv_state_e              state_q, state_d;
  logic [BCD_W+BIN_W-1:0]   sh_q, sh_d;
  logic [3:0]               iter_q, iter_d;
  logic                     ovf_q, ovf_d;
  logic [BCD_W-1:0]         adj;

  always_ff @(posedge sysclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      iter_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      iter_q  <= iter_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    iter_d  = iter_q;
    ovf_d   = ovf_q;
    done_o  = 1'b0;

    adj = sh_q[BCD_W+BIN_W-1:BIN_W];
    for (int unsigned n = 0; n < NUM_DIGITS; n++) begin
      if (adj[4*n +: 4] >= 4'd5) adj[4*n +: 4] = adj[4*n +: 4] + 4'd3;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          ovf_d   = (bin_i > MAX_VALUE);
          sh_d    = {{BCD_W{1'b0}}, (bin_i > MAX_VALUE) ? MAX_VALUE : bin_i};
          iter_d  = '0;
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        sh_d = {adj[BCD_W-2:0], sh_q[BIN_W-1:0], 1'b0};
        if (iter_q == LAST_ITER) state_d = ST_LOAD;
        else                     iter_d  = iter_q + 4'd1;
      end
      ST_LOAD: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o = (state_q != ST_IDLE);
  assign bcd_o  = sh_q[BCD_W+BIN_W-1:BIN_W];
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/fnd_display_driver.sv
// Decimal 4-digit multiplexed common-anode FND driver fed by the up-counter value.
module fnd_display_driver
  import fnd_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 120000,
  parameter int unsigned SYNC_STAGES = 2
)(
  input  logic              sysclk,
  input  logic              i_rst_n,
  input  logic [BIN_W-1:0]  i_value,
  input  logic              i_lz_blank,
  output logic [7:0]        o_seg,
  output logic [3:0]        o_digit,
  output logic              o_busy,
  output logic              o_ovf
);

  localparam int unsigned   SCW       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);

  logic [BIN_W-1:0]   sync_q [SYNC_STAGES];
  logic [SYNC_STAGES:0] vld_q;
  logic [BIN_W-1:0]   smp, prev_q, last_q;
  logic               have_q, accept;

  logic               conv_busy, conv_done, conv_ovf;
  logic [BCD_W-1:0]   conv_bcd, disp_q;
  logic               ovf_q;

  logic [SCW-1:0]     scan_q;
  logic [1:0]         idx_q;
  logic [7:0]         seg_q, seg_d;
  logic [3:0]         dig_q;
  logic [NUM_DIGITS-1:0] blank;
  logic               zero_above;

  assign smp = sync_q[SYNC_STAGES-1];

  // vld_q keeps post-reset flop contents from posing as a real stable sample.
  assign accept = vld_q[SYNC_STAGES] && (smp == prev_q) &&
                  (!have_q || (smp != last_q)) && !conv_busy;

  always_ff @(posedge sysclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      vld_q  <= '0;
      prev_q <= '0;
      last_q <= '0;
      have_q <= 1'b0;
    end else begin
      sync_q[0] <= i_value;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      vld_q  <= {vld_q[SYNC_STAGES-1:0], 1'b1};
      prev_q <= smp;
      if (accept) begin
        last_q <= smp;
        have_q <= 1'b1;
      end
    end
  end

  bin2bcd_seq u_conv (
    .sysclk  (sysclk),
    .i_rst_n (i_rst_n),
    .start_i (accept),
    .bin_i   (smp),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd),
    .ovf_o   (conv_ovf)
  );

  always_ff @(posedge sysclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      disp_q <= '0;
      ovf_q  <= 1'b0;
    end else if (conv_done) begin
      disp_q <= conv_bcd;
      ovf_q  <= conv_ovf;
    end
  end

  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int unsigned k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above && (disp_q[4*k +: 4] == 4'd0);
      blank[k]   = zero_above && i_lz_blank;
    end
    seg_d = blank[idx_q] ? BLANK_SEG : seg_decode(disp_q[{idx_q, 2'b00} +: 4]);
  end

  always_ff @(posedge sysclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scan_q <= '0;
      idx_q  <= '0;
      seg_q  <= BLANK_SEG;
      dig_q  <= '1;
    end else begin
      if (scan_q == SCAN_LAST) begin
        scan_q <= '0;
        idx_q  <= idx_q + 2'd1;
      end else begin
        scan_q <= scan_q + 1'b1;
      end
      seg_q <= seg_d;
      dig_q <= ~(4'b0001 << idx_q);
    end
  end

  assign o_seg   = seg_q;
  assign o_digit = dig_q;
  assign o_busy  = conv_busy;
  assign o_ovf   = ovf_q;

endmodule

// File: doc/fnd_display_driver.md
Name: fnd_display_driver

Overview:
Reads the 14-bit up-counter value and shows it in decimal on a 4-digit multiplexed 7-segment display (common anode, active-low segments and digit enables). A sequential shift-add-3 converter turns binary into BCD. A prescaled scan counter refreshes one digit at a time. The block sits between the counter's o_upCounter output and the board FND pins.

Parameters:
SCAN_DIV, 120000, sysclk cycles per digit slot (1 kHz digit rate at 120 MHz); minimum 2.
SYNC_STAGES, 2, synchronizer depth for i_value, which comes from the prescaled-clock domain.

Ports:
sysclk  in  1  system clock
i_rst_n  in  1  reset; asynchronous, active-low
i_value  in  14  binary count from the up-counter; nominal range 0..9999
i_lz_blank  in  1  1 = blank leading zeros (ones digit is never blanked)
o_seg  out  8  {dp,g,f,e,d,c,b,a}; active-low; dp is always 1 (off)
o_digit  out  4  one-hot active-low digit enable; bit0 = ones, bit3 = thousands
o_busy  out  1  high while a conversion is in progress
o_ovf  out  1  high while the displayed value was clamped from an input >9999

Behaviour:
- Reset values: o_seg=8'hFF, o_digit=4'hF, o_busy=0, o_ovf=0; BCD display registers 0; FSM IDLE; scan counter 0; digit index 0.
- Input capture: i_value passes through SYNC_STAGES flops. A candidate is accepted only when two consecutive synchronized samples are equal and differ from the last converted value. The first equal pair after reset is always accepted.
- FSM states:
  - IDLE: on an accepted candidate, load the converter, set o_busy=1, and go to CONV.
  - CONV: perform exactly 14 shift-add-3 iterations, one per cycle. Before each shift, add 3 to every BCD nibble that is >=5.
  - LOAD: copy the 4 BCD nibbles into the display registers, update o_ovf, clear o_busy, and return to IDLE.
- Latency: 16 sysclk from the accept cycle to updated display registers (1 load + 14 CONV + 1 LOAD).
- Clamp: an input >9999 (10000..16383) is converted as 9999 and sets o_ovf=1 at LOAD. An in-range value clears o_ovf at LOAD.
- A new input while o_busy=1 is not accepted. Conversion completes with the old value, and the new value is accepted in IDLE on the next cycle once it is stable. Values are never dropped permanently.
- Scan:
  - The scan counter runs 0..SCAN_DIV-1. On wrap, the digit index goes 0→1→2→3→0.
  - o_digit and o_seg are registered, so both change on the same edge, one cycle after the wrap.
  - The scan runs continuously and is independent of the FSM. The display registers change only in LOAD, so a digit never shows a partial conversion.
- Segment decode, active-low gfedcba:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (with dp=1 in bit7).
  - Nibble codes 10..15 cannot occur; decode them to blank (FF).
- Leading-zero blanking (i_lz_blank=1): digit k≥1 shows FF when it and all higher digits are 0. i_lz_blank is sampled combinationally at decode, with no synchronizer; it is a static switch.
- Reset mid-conversion aborts: the FSM returns to IDLE, display registers go to 0, and o_busy goes to 0 asynchronously.
- Widths: the BCD shift register is 16+14=30 bits. The scan counter is $clog2(SCAN_DIV) bits. The digit index is 2 bits and wraps naturally.

Decomposition:
- Package fnd_pkg contains:
  - constants NUM_DIGITS=4, MAX_VALUE=14'd9999, BLANK_SEG=8'hFF;
  - the 10-entry segment pattern constant array;
  - state encoding localparams ST_IDLE/ST_CONV/ST_LOAD;
  - a seg_decode function.
- One sub-module: bin2bcd_seq, holding the IDLE/CONV/LOAD FSM and the iteration counter, with a start/busy/done handshake. The top holds the synchronizer, stability check, scan and decode.

Test Plan:
- Reset check: hold i_rst_n=0 with i_value=1234, then release → o_seg=FF and o_digit=F during reset. After release, the display shows 1,2,3,4 in order; o_busy is high for exactly 15 cycles, 16 cycles after stable input.
- Scan order (SCAN_DIV=4) with i_value=1234: o_digit cycles E,D,B,7 every 4 clocks, with o_seg=99 on E, B0 on D, A4 on B, F9 on 7.
- Leading-zero blanking, i_value=7:
  - i_lz_blank=1 → digits 3..1 show FF and digit 0 shows F8;
  - i_lz_blank=0 → the higher digits show C0.
- Clamp and recovery:
  - i_value=12000 → all four digits show 90 (9999) and o_ovf=1;
  - then i_value=42 → o_ovf=0 and the display shows 0042 (or blanked 42).
- Input changing mid-conversion:
  - i_value steps 5→6 while o_busy=1 → display shows 5 first, then 6 after a second conversion.
  - A single-cycle glitch value (one synchronized sample only) is never displayed.
- Reset mid-conversion: assert i_rst_n=0 at CONV iteration 7 → o_busy=0 immediately and the display registers are 0. After release, the stable input is re-accepted and displayed correctly.
